// File: rtl/iu_fpu_ctl.sv
// IU-to-FPU handshake controller: issues one FP operation at a time and returns the captured result.
// Optional FPU_TIMEOUT_EN adds a WAIT-cycle watchdog that aborts a stuck FPU operation.
module iu_fpu_ctl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        req_valid,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        iu_hold,
  input  logic        iu_kill,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [7:0]  fpop,
  output logic        fpop_valid,
  output logic [31:0] fpain,
  output logic [31:0] fpbin,
  output logic        fphold,
  output logic        fpkill,
  input  logic        fpbusyn,
  input  logic [31:0] fpout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_accept;
  logic        w_complete;
  logic        w_kill;
  logic        w_timeout;
  logic [7:0]  r_fpop;
  logic [31:0] r_fpain;
  logic [31:0] r_fpbin;
  logic        r_fpkill;
  logic        r_res_valid;
  logic [31:0] r_res_data;

`ifdef FPU_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_cnt;
  logic        r_res_err;
`endif

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_kill       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && !iu_kill) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (iu_kill) begin
          w_kill       = 1'b1;
          w_state_next = S_IDLE;
        end else if (!iu_hold) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Kill beats completion, completion beats the watchdog.
        if (iu_kill) begin
          w_kill       = 1'b1;
          w_state_next = S_IDLE;
        end else if (fpbusyn && !iu_hold) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
`ifdef FPU_TIMEOUT_EN
        else if (!iu_hold && (r_cnt >= TO_LAST)) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= S_IDLE;
      r_fpop      <= 8'h00;
      r_fpain     <= 32'h0;
      r_fpbin     <= 32'h0;
      r_fpkill    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_fpkill    <= w_kill | w_timeout;
      r_res_valid <= w_complete | w_timeout;
      if (w_accept) begin
        r_fpop  <= req_op;
        r_fpain <= req_a;
        r_fpbin <= req_b;
      end
      if (w_complete) begin
        r_res_data <= fpout;
      end else if (w_timeout) begin
        r_res_data <= 32'h0;
      end
    end
  end

`ifdef FPU_TIMEOUT_EN
  // Counts only non-hold WAIT cycles; anything outside WAIT clears it so each entry starts at 0.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_cnt     <= 32'h0;
      r_res_err <= 1'b0;
    end else begin
      r_res_err <= w_timeout;
      if (r_state != S_WAIT) begin
        r_cnt <= 32'h0;
      end else if (!iu_hold) begin
        r_cnt <= r_cnt + 32'h1;
      end
    end
  end

  assign res_err = r_res_err;
`else
  assign res_err = 1'b0;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign fpop_valid = (r_state == S_ISSUE);
  assign fphold     = (r_state != S_IDLE) && iu_hold;
  assign fpkill     = r_fpkill;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign fpop       = r_fpop;
  assign fpain      = r_fpain;
  assign fpbin      = r_fpbin;

endmodule

// File: tb/tb_iu_fpu_ctl.sv
// Self-checking bench for iu_fpu_ctl: directed scenarios plus randomized hold/busy transactions
// checked against a cycle-count reference model derived from the handshake rules.
module tb_iu_fpu_ctl;

`ifdef FPU_TIMEOUT_EN
  localparam int TB_TO = 32;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk;
  logic        reset_l;
  logic        req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        iu_hold;
  logic        iu_kill;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;
  logic [7:0]  fpop;
  logic        fpop_valid;
  logic [31:0] fpain;
  logic [31:0] fpbin;
  logic        fphold;
  logic        fpkill;
  logic        fpbusyn;
  logic [31:0] fpout;

  int          checks;
  int          failures;
  logic [31:0] exp_res_data;

  iu_fpu_ctl #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .iu_hold    (iu_hold),
    .iu_kill    (iu_kill),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_err    (res_err),
    .fpop       (fpop),
    .fpop_valid (fpop_valid),
    .fpain      (fpain),
    .fpbin      (fpbin),
    .fphold     (fphold),
    .fpkill     (fpkill),
    .fpbusyn    (fpbusyn),
    .fpout      (fpout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for a cycle are driven 1ns after its rising edge and outputs sampled 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    iu_hold   = 1'b0;
    iu_kill   = 1'b0;
    fpbusyn   = 1'b1;
    fpout     = 32'h0;
  endtask

  task automatic test_reset();
    logic [111:0] got;
    reset_l = 1'b0;
    idle_inputs();
    req_op = 8'h0; req_a = 32'h0; req_b = 32'h0;
    iu_hold = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    got = {fpop, fpain, fpbin, fpop_valid, fpkill, res_valid, res_err, res_data, fphold, req_ready};
    checks++;
    if (got !== {8'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", got,
               {8'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
    end
    next_cycle();
    reset_l = 1'b1;
    iu_hold = 1'b0;
    next_cycle();
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || fpkill !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b rv=%b kill=%b exp 1 0 0", req_ready, res_valid, fpkill);
    end
    exp_res_data = 32'h0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] b;
    b = $urandom;
    next_cycle();
    idle_inputs();
    req_valid = 1'b1; req_op = 8'h62; req_a = 32'h3F800000; req_b = b;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL basic_ready_c0 got=%b exp=1", req_ready);
    end
    next_cycle();
    req_valid = 1'b0; req_op = 8'hFF; req_a = 32'hDEAD0000; req_b = 32'h0;
    #1;
    checks++;
    if (fpop_valid !== 1'b1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL basic_c1 got fpop_valid=%b ready=%b exp 1 0", fpop_valid, req_ready);
    end
    checks++;
    if ({fpop, fpain, fpbin} !== {8'h62, 32'h3F800000, b}) begin
      failures++; $display("FAIL basic_operands got=%h %h %h exp=62 3f800000 %h", fpop, fpain, fpbin, b);
    end
    next_cycle();
    #1;
    checks++;
    if (fpop_valid !== 1'b0 || res_valid !== 1'b0) begin
      failures++; $display("FAIL basic_c2 got fpop_valid=%b res_valid=%b exp 0 0", fpop_valid, res_valid);
    end
    next_cycle();
    #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0 || res_err !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_c3 got rv=%b data=%h err=%b ready=%b exp 1 0 0 1", res_valid, res_data, res_err, req_ready);
    end
    next_cycle();
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL basic_c4_pulse got=%b exp=0", res_valid);
    end
    exp_res_data = 32'h0;
    $display("test_basic done");
  endtask

  // Model: ISSUE ends at the first cycle >=1 without hold; the result is captured in the first
  // later cycle with fpbusyn=1 and no hold, and appears one cycle after that.
  task automatic test_random();
    logic        h [0:39];
    logic        bz [0:39];
    int          bs, last_issue, done;
    logic [7:0]  op;
    logic [31:0] a, b, val;
    for (int t = 0; t < 30; t++) begin
      op = 8'($urandom); a = $urandom; b = $urandom; val = $urandom;
      bs = $urandom_range(2, 10);
      if (t == 0) begin
        bs = 7; val = 32'h40000000;
      end
      for (int k = 0; k < 40; k++) begin
        h[k]  = (t != 0) && (k < 20) && ($urandom_range(0, 2) == 0);
        bz[k] = (k >= bs);
      end
      last_issue = 1;
      while (h[last_issue]) last_issue++;
      done = last_issue + 1;
      while (!(bz[done] && !h[done])) done++;
      for (int k = 0; k <= done + 1; k++) begin
        next_cycle();
        req_valid = (k == 0);
        req_op = (k == 0) ? op : 8'($urandom);
        req_a  = (k == 0) ? a  : $urandom;
        req_b  = (k == 0) ? b  : $urandom;
        iu_hold = (k <= done) ? h[k] : 1'b0;
        iu_kill = 1'b0;
        fpbusyn = bz[k];
        fpout   = bz[k] ? val : $urandom;
        #1;
        checks++;
        if (fpop_valid !== (k >= 1 && k <= last_issue)) begin
          failures++; $display("FAIL rnd_fpop_valid t=%0d k=%0d got=%b exp=%b", t, k, fpop_valid, (k >= 1 && k <= last_issue));
        end
        checks++;
        if (fphold !== (k >= 1 && k <= done && h[k])) begin
          failures++; $display("FAIL rnd_fphold t=%0d k=%0d got=%b exp=%b", t, k, fphold, (k >= 1 && k <= done && h[k]));
        end
        checks++;
        if (res_valid !== (k == done + 1) || req_ready !== (k == 0 || k == done + 1)) begin
          failures++;
          $display("FAIL rnd_handshake t=%0d k=%0d got rv=%b ready=%b exp rv=%b ready=%b",
                   t, k, res_valid, req_ready, (k == done + 1), (k == 0 || k == done + 1));
        end
        checks++;
        if (res_data !== ((k == done + 1) ? val : exp_res_data) || res_err !== 1'b0 || fpkill !== 1'b0) begin
          failures++;
          $display("FAIL rnd_result t=%0d k=%0d got data=%h err=%b kill=%b exp data=%h err=0 kill=0",
                   t, k, res_data, res_err, fpkill, (k == done + 1) ? val : exp_res_data);
        end
        if (k >= 1) begin
          checks++;
          if ({fpop, fpain, fpbin} !== {op, a, b}) begin
            failures++; $display("FAIL rnd_operands t=%0d k=%0d got=%h %h %h exp=%h %h %h", t, k, fpop, fpain, fpbin, op, a, b);
          end
        end
      end
      exp_res_data = val;
      $display("test_random txn=%0d op=%h issue_end=%0d done=%0d data=%h", t, op, last_issue, done, val);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1, v2;
    int          n_valid;
    v1 = $urandom; v2 = $urandom;
    n_valid = 0;
    for (int k = 0; k <= 7; k++) begin
      next_cycle();
      idle_inputs();
      req_valid = (k == 0 || k == 3);
      req_op = (k == 3) ? 8'h6A : 8'h62;
      req_a  = (k == 3) ? 32'h11111111 : 32'h22222222;
      req_b  = 32'h0;
      fpout  = (k == 2) ? v1 : ((k == 5) ? v2 : $urandom);
      #1;
      if (res_valid === 1'b1) n_valid++;
      if (k == 3) begin
        checks++;
        if (res_valid !== 1'b1 || res_data !== v1 || req_ready !== 1'b1) begin
          failures++; $display("FAIL b2b_first got rv=%b data=%h ready=%b exp 1 %h 1", res_valid, res_data, req_ready, v1);
        end
      end
      if (k == 4) begin
        checks++;
        if (fpop_valid !== 1'b1 || fpop !== 8'h6A || fpain !== 32'h11111111) begin
          failures++; $display("FAIL b2b_issue got v=%b op=%h a=%h exp 1 6a 11111111", fpop_valid, fpop, fpain);
        end
      end
      if (k == 6) begin
        checks++;
        if (res_valid !== 1'b1 || res_data !== v2) begin
          failures++; $display("FAIL b2b_second got rv=%b data=%h exp 1 %h", res_valid, res_data, v2);
        end
      end
    end
    checks++;
    if (n_valid != 2) begin
      failures++; $display("FAIL b2b_count got=%0d exp=2", n_valid);
    end
    exp_res_data = v2;
    $display("test_back_to_back done results=%0d", n_valid);
  endtask

  task automatic test_hold();
    int          n_fv, n_fh;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    n_fv = 0; n_fh = 0;
    for (int k = 0; k <= 7; k++) begin
      next_cycle();
      idle_inputs();
      req_valid = (k == 0);
      req_op = (k == 0) ? 8'h66 : 8'h00;
      req_a  = (k == 0) ? a : 32'h0;
      req_b  = (k == 0) ? b : 32'h0;
      iu_hold = (k >= 1 && k <= 3);
      fpout = 32'h12345678;
      #1;
      if (fpop_valid === 1'b1) n_fv++;
      if (fphold === 1'b1) n_fh++;
      checks++;
      if (fphold !== (k >= 1 && k <= 3)) begin
        failures++; $display("FAIL hold_fphold k=%0d got=%b exp=%b", k, fphold, (k >= 1 && k <= 3));
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if ({fpop, fpain, fpbin} !== {8'h66, a, b}) begin
          failures++; $display("FAIL hold_operands k=%0d got=%h %h %h exp=66 %h %h", k, fpop, fpain, fpbin, a, b);
        end
      end
      checks++;
      if (res_valid !== (k == 6)) begin
        failures++; $display("FAIL hold_res_valid k=%0d got=%b exp=%b", k, res_valid, (k == 6));
      end
    end
    checks++;
    if (n_fv != 4 || n_fh != 3) begin
      failures++; $display("FAIL hold_counts got fpop_valid=%0d fphold=%0d exp 4 3", n_fv, n_fh);
    end
    exp_res_data = 32'h12345678;
    $display("test_hold done fpop_valid_cycles=%0d fphold_cycles=%0d", n_fv, n_fh);
  endtask

  task automatic test_kill();
    // Kill in the second WAIT cycle, while the FPU also reports done.
    for (int k = 0; k <= 6; k++) begin
      next_cycle();
      idle_inputs();
      req_valid = (k == 0);
      req_op = 8'h63;
      iu_kill = (k == 3);
      fpbusyn = (k == 3);
      fpout = 32'hAAAA5555;
      #1;
      checks++;
      if (fpkill !== (k == 4) || res_valid !== 1'b0) begin
        failures++; $display("FAIL kill_wait k=%0d got kill=%b rv=%b exp kill=%b rv=0", k, fpkill, res_valid, (k == 4));
      end
      if (k == 4) begin
        checks++;
        if (req_ready !== 1'b1 || res_data !== exp_res_data) begin
          failures++; $display("FAIL kill_wait_idle got ready=%b data=%h exp 1 %h", req_ready, res_data, exp_res_data);
        end
      end
    end
    // Kill during ISSUE.
    for (int k = 0; k <= 3; k++) begin
      next_cycle();
      idle_inputs();
      req_valid = (k == 0);
      iu_kill = (k == 1);
      #1;
      checks++;
      if (fpkill !== (k == 2) || res_valid !== 1'b0 || (k == 2 && req_ready !== 1'b1)) begin
        failures++; $display("FAIL kill_issue k=%0d got kill=%b rv=%b ready=%b", k, fpkill, res_valid, req_ready);
      end
    end
    // Kill coinciding with a request in IDLE drops it without a kill pulse.
    for (int k = 0; k <= 2; k++) begin
      next_cycle();
      idle_inputs();
      req_valid = (k == 0);
      req_op = 8'h99;
      iu_kill = (k == 0);
      #1;
      if (k >= 1) begin
        checks++;
        if (fpkill !== 1'b0 || fpop_valid !== 1'b0 || req_ready !== 1'b1 || fpop !== 8'h63) begin
          failures++;
          $display("FAIL kill_idle k=%0d got kill=%b fv=%b ready=%b op=%h exp 0 0 1 63", k, fpkill, fpop_valid, req_ready, fpop);
        end
      end
    end
    $display("test_kill done");
  endtask

  task automatic test_reset_mid();
    logic [111:0] got;
    for (int k = 0; k <= 3; k++) begin
      next_cycle();
      idle_inputs();
      req_valid = (k == 0);
      req_op = 8'h6E; req_a = 32'h5; req_b = 32'h7;
      fpbusyn = 1'b0;
      #1;
    end
    checks++;
    if (req_ready !== 1'b0 || fpop_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_in_wait got ready=%b fv=%b exp 0 0", req_ready, fpop_valid);
    end
    reset_l = 1'b0;
    iu_hold = 1'b1;
    #1;
    got = {fpop, fpain, fpbin, fpop_valid, fpkill, res_valid, res_err, res_data, fphold, req_ready};
    checks++;
    if (got !== {8'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_values got=%h exp=%h", got,
               {8'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
    end
    fpbusyn = 1'b1; iu_hold = 1'b0;
    next_cycle();
    next_cycle();
    reset_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      #1;
      checks++;
      if (res_valid !== 1'b0 || fpkill !== 1'b0 || req_ready !== 1'b1) begin
        failures++; $display("FAIL rstmid_after k=%0d got rv=%b kill=%b ready=%b exp 0 0 1", k, res_valid, fpkill, req_ready);
      end
    end
    exp_res_data = 32'h0;
    $display("test_reset_mid done");
  endtask

`ifdef FPU_TIMEOUT_EN
  task automatic test_timeout();
    int fire;
    // fpbusyn stuck low: the TB_TO-th non-hold WAIT cycle (cycle TB_TO+1) triggers the abort.
    fire = TB_TO + 2;
    for (int k = 0; k <= fire + 1; k++) begin
      next_cycle();
      idle_inputs();
      req_valid = (k == 0);
      fpbusyn = 1'b0;
      fpout = 32'hFFFFFFFF;
      #1;
      checks++;
      if (res_valid !== (k == fire) || fpkill !== (k == fire) || res_err !== (k == fire)) begin
        failures++;
        $display("FAIL timeout k=%0d got rv=%b kill=%b err=%b exp %b", k, res_valid, fpkill, res_err, (k == fire));
      end
      if (k == fire) begin
        checks++;
        if (res_data !== 32'h0 || req_ready !== 1'b1) begin
          failures++; $display("FAIL timeout_data got data=%h ready=%b exp 0 1", res_data, req_ready);
        end
      end
    end
    // Result arriving on the limit cycle wins over the timeout.
    for (int k = 0; k <= fire; k++) begin
      next_cycle();
      idle_inputs();
      req_valid = (k == 0);
      fpbusyn = (k == fire - 1);
      fpout = 32'h0BADF00D;
      #1;
      if (k == fire) begin
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b0 || fpkill !== 1'b0 || res_data !== 32'h0BADF00D) begin
          failures++;
          $display("FAIL timeout_tie got rv=%b err=%b kill=%b data=%h exp 1 0 0 0badf00d", res_valid, res_err, fpkill, res_data);
        end
      end
    end
    $display("test_timeout done limit=%0d", TB_TO);
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    exp_res_data = 32'h0;
    reset_l = 1'b0;
    idle_inputs();
    req_op = 8'h0; req_a = 32'h0; req_b = 32'h0;
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_hold();
    test_kill();
    test_reset_mid();
`ifdef FPU_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iu_fpu_ctl.md
IU_FPU_CTL -- requirements
Module: iu_fpu_ctl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning the WAIT-cycle limit before forced abort; used only when FPU_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 reset_l  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  IU pipeline presents an FP operation.
REQ-005 req_op  input  8  Java FP opcode.
REQ-006 req_a, req_b  input  32 each  operands A and B.
REQ-007 req_ready  output  1  controller idle; request accepted when req_valid & req_ready.
REQ-008 iu_hold  input  1  IU pipeline stall.
REQ-009 iu_kill  input  1  IU abort of the in-flight operation.
REQ-010 res_valid  output  1  one-cycle result strobe.
REQ-011 res_data  output  32  captured FPU result.
REQ-012 res_err  output  1  result aborted by timeout; qualified by res_valid.
REQ-013 fpop  output  8  opcode to FPU.
REQ-014 fpop_valid  output  1  opcode/operands valid to FPU.
REQ-015 fpain, fpbin  output  32 each  operand buses to FPU.
REQ-016 fphold  output  1  hold to FPU.
REQ-017 fpkill  output  1  kill to FPU.
REQ-018 fpbusyn  input  1  FPU busy, active low; high means result on fpout is valid.
REQ-019 fpout  input  32  FPU result bus.

Function
REQ-020 States: IDLE, ISSUE, WAIT; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: when req_valid=1 and iu_kill=0, register req_op/req_a/req_b into fpop/fpain/fpbin and go to ISSUE; when iu_kill=1, drop the request, stay in IDLE, and leave fpkill at 0.
REQ-022 ISSUE: fpop_valid=1; if iu_hold=0, go to WAIT next cycle; if iu_hold=1, stay in ISSUE with fpop/fpain/fpbin/fpop_valid stable.
REQ-023 WAIT: fpop_valid=0; if fpbusyn=1 and iu_hold=0, capture fpout into res_data, assert res_valid for exactly the next cycle, and go to IDLE; otherwise stay in WAIT.
REQ-024 fphold SHALL equal iu_hold while in ISSUE or WAIT, and 0 in IDLE (combinational).
REQ-025 iu_kill=1 in ISSUE or WAIT: fpkill=1 for exactly the next cycle, go to IDLE, no res_valid; kill has priority over completion in the same cycle.
REQ-026 Latency with fpbusyn=1 and no hold: request accepted cycle N, fpop_valid cycle N+1, res_valid and req_ready cycle N+3; back-to-back acceptance in cycle N+3 is legal.
REQ-027 res_data SHALL hold its value until the next capture; fpop/fpain/fpbin SHALL hold until the next acceptance.

Reset
REQ-028 reset_l=0 SHALL force IDLE asynchronously, including mid-ISSUE/WAIT, with no fpkill pulse.
REQ-029 Reset values: fpop=0, fpain=0, fpbin=0, fpop_valid=0, fpkill=0, res_valid=0, res_err=0, res_data=0, fphold=0, req_ready=1.

Configuration
REQ-030 FPU_TIMEOUT_EN defined: a counter SHALL count non-hold WAIT cycles, cleared on WAIT entry; when it reaches TIMEOUT_CYCLES, fpkill=1 for one cycle, res_valid=1 with res_err=1 and res_data=0, and the state SHALL go to IDLE.
REQ-031 When the timeout count and fpbusyn=1 coincide, the result SHALL win (res_err=0).
REQ-032 FPU_TIMEOUT_EN undefined: no counter, res_err tied 0, WAIT lasts indefinitely.

Verification
REQ-033 Stub FPU (fpbusyn=1, fpout=0); request op=0x62, a=0x3F800000 in cycle 0 -> fpop_valid=1 in cycle 1; res_valid=1 with res_data=0 in cycle 3; req_ready=1 in cycle 3.
REQ-034 FPU model holds fpbusyn=0 for 5 cycles, then fpout=0x40000000 -> res_valid exactly 1 cycle after fpbusyn rises, res_data=0x40000000, res_err=0.
REQ-035 iu_hold=1 for 3 cycles during ISSUE -> fpop_valid asserted for 4 cycles, fphold=1 for the 3 hold cycles, operands unchanged.
REQ-036 iu_kill in the 2nd WAIT cycle -> fpkill pulse of 1 cycle, no res_valid, req_ready=1 next cycle; iu_kill in IDLE with req_valid -> no fpkill.
REQ-037 reset_l pulsed low mid-WAIT -> all outputs at reset values immediately, no res_valid afterward.
REQ-038 FPU_TIMEOUT_EN, TIMEOUT_CYCLES=4, fpbusyn stuck 0 -> fpkill and res_valid with res_err=1, res_data=0 after 4 WAIT cycles.
